// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and constants for the round-robin 4:1 mux arbiter.
// Holds the state encoding, the requester/select widths and a few small helper functions.
package rr_mux4_arbiter_pkg;

   localparam int unsigned REQ_N = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic {
      StIdle  = 1'b0,
      StGrant = 1'b1
   } state_e;

   // Hold counter width; a counter of at least one bit is kept even when MAX_HOLD is 1.
   function automatic int unsigned hold_width(int unsigned max_hold);
      return (max_hold <= 2) ? 1 : $clog2(max_hold);
   endfunction

   function automatic logic [REQ_N-1:0] onehot(logic [SEL_W-1:0] idx);
      return REQ_N'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// Request/data/grant bundle between four requesters and the arbiter.
// The master side drives requests and data; the slave side (the arbiter) returns grant and output.
interface rr_mux4_arbiter_if
   import rr_mux4_arbiter_pkg::*;
#(
   parameter int unsigned DW = 8
);
   logic [REQ_N-1:0] req;
   logic [DW-1:0]    in0;
   logic [DW-1:0]    in1;
   logic [DW-1:0]    in2;
   logic [DW-1:0]    in3;
   logic [REQ_N-1:0] gnt;
   logic [SEL_W-1:0] sel;
   logic [DW-1:0]    out;
   logic             out_vld;

   modport master (
      output req, in0, in1, in2, in3,
      input  gnt, sel, out, out_vld
   );

   modport slave (
      input  req, in0, in1, in2, in3,
      output gnt, sel, out, out_vld
   );
endinterface

// File: rtl/rr_pick4.sv
// Combinational rotating priority encoder: searches req starting at ptr, wrapping mod 4.
// win is only meaningful when any is set.
module rr_pick4
   import rr_mux4_arbiter_pkg::*;
(
   input  logic [REQ_N-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic             any,
   output logic [SEL_W-1:0] win
);

   logic [SEL_W-1:0] idx;

   // Scan from the farthest offset down so the nearest set bit after ptr is the last write.
   always_comb begin
      any = |req;
      win = ptr;
      idx = ptr;
      for (int off = REQ_N - 1; off >= 0; off--) begin
         idx = ptr + SEL_W'(off);
         if (req[idx]) begin
            win = idx;
         end
      end
   end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter for four requesters sharing a registered 4:1 data mux.
// Grants one requester for at most MAX_HOLD cycles, re-arbitrating without a bubble on release.
module rr_mux4_arbiter
   import rr_mux4_arbiter_pkg::*;
#(
   parameter int unsigned DW       = 8,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   rr_mux4_arbiter_if.slave bus
);

   localparam int unsigned         HOLD_W    = hold_width(MAX_HOLD);
   localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_e           state_q, state_d;
   logic [REQ_N-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [DW-1:0]    out_q;
   logic             out_vld_q;

   logic [SEL_W-1:0] sel_next;
   logic [SEL_W-1:0] pick_ptr;
   logic             pick_any;
   logic [SEL_W-1:0] pick_win;
   logic             release_gnt;
   logic [DW-1:0]    mux_data;

   assign sel_next = sel_q + SEL_W'(1);

   // While granted, the picker already searches from sel+1 so a release can hand over in one edge.
   assign pick_ptr = (state_q == StGrant) ? sel_next : ptr_q;

   rr_pick4 u_pick (
      .req (bus.req),
      .ptr (pick_ptr),
      .any (pick_any),
      .win (pick_win)
   );

   assign release_gnt = !bus.req[sel_q] || (hold_q == HOLD_LAST);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      unique case (state_q)
         StIdle: begin
            gnt_d = '0;
            if (pick_any) begin
               state_d = StGrant;
               gnt_d   = onehot(pick_win);
               sel_d   = pick_win;
               hold_d  = '0;
            end
         end
         StGrant: begin
            if (!release_gnt) begin
               hold_d = hold_q + HOLD_W'(1);
            end else begin
               ptr_d  = sel_next;
               hold_d = '0;
               if (pick_any) begin
                  gnt_d = onehot(pick_win);
                  sel_d = pick_win;
               end else begin
                  state_d = StIdle;
                  gnt_d   = '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      mux_data = bus.in0;
      unique case (sel_q)
         2'd0: mux_data = bus.in0;
         2'd1: mux_data = bus.in1;
         2'd2: mux_data = bus.in2;
         2'd3: mux_data = bus.in3;
         default: mux_data = bus.in0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   // out only loads during granted cycles, so it keeps its last value while out_vld is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q     <= '0;
         out_vld_q <= 1'b0;
      end else begin
         out_vld_q <= (state_q == StGrant);
         if (state_q == StGrant) begin
            out_q <= mux_data;
         end
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.sel     = sel_q;
   assign bus.out     = out_q;
   assign bus.out_vld = out_vld_q;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Scoreboard bench for rr_mux4_arbiter: a behavioural owner/held-count model predicts each cycle,
// and a negedge monitor pops and compares against the DUT outputs.
module tb_rr_mux4_arbiter;
   import rr_mux4_arbiter_pkg::*;

   localparam int DW       = 8;
   localparam int MAX_HOLD = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   rr_mux4_arbiter_if #(.DW(DW)) bus ();

   rr_mux4_arbiter #(
      .DW       (DW),
      .MAX_HOLD (MAX_HOLD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]    gnt;
      logic [1:0]    sel;
      logic [DW-1:0] out;
      logic          vld;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Model: owner = granted index (-1 idle), held = cycles granted so far, ptr = search start.
   int            m_owner;
   int            m_held;
   int            m_ptr;
   int            m_sel;
   logic [DW-1:0] m_out;
   logic          m_vld;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] din(input int i);
      case (i)
         0:       return bus.in0;
         1:       return bus.in1;
         2:       return bus.in2;
         default: return bus.in3;
      endcase
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
      m_sel   = 0;
      m_out   = '0;
      m_vld   = 1'b0;
   endtask

   task automatic step(input logic [3:0] r, input bit rnd);
      exp_t e;
      bus.req = r;
      if (rnd) begin
         bus.in0 = DW'($urandom);
         bus.in1 = DW'($urandom);
         bus.in2 = DW'($urandom);
         bus.in3 = DW'($urandom);
      end else begin
         bus.in0 = 8'hA0;
         bus.in1 = 8'hB1;
         bus.in2 = 8'hC2;
         bus.in3 = 8'hD3;
      end
      @(posedge clk);
      if (m_owner >= 0) m_out = din(m_owner);
      m_vld = (m_owner >= 0);
      if (m_owner >= 0 && r[m_owner] && m_held < MAX_HOLD) begin
         m_held++;
      end else begin
         if (m_owner >= 0) m_ptr = (m_owner + 1) % 4;
         m_owner = -1;
         for (int k = 0; k < 4; k++) begin
            if (m_owner < 0 && r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
         end
         if (m_owner >= 0) begin
            m_held = 1;
            m_sel  = m_owner;
         end
      end
      e.gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      e.sel = 2'(m_sel);
      e.out = m_out;
      e.vld = m_vld;
      sb.push_back(e);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_sel", 32'(bus.sel), 32'd0);
      check("rst_out", 32'(bus.out), 32'd0);
      check("rst_vld", 32'(bus.out_vld), 32'd0);
      sb.delete();
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         check("gnt", 32'(bus.gnt), 32'(mon_e.gnt));
         check("sel", 32'(bus.sel), 32'(mon_e.sel));
         check("out_vld", 32'(bus.out_vld), 32'(mon_e.vld));
         check("out", 32'(bus.out), 32'(mon_e.out));
      end
   end

   initial begin
      logic [3:0] r;
      bus.req = 4'b0000;
      bus.in0 = 8'hA0;
      bus.in1 = 8'hB1;
      bus.in2 = 8'hC2;
      bus.in3 = 8'hD3;
      model_reset();
      #2;
      do_reset();

      // Single requester, then release to idle
      for (int i = 0; i < 3; i++) step(4'b0001, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);

      // Full contention rotation
      for (int i = 0; i < 22; i++) step(4'b1111, 1'b0);

      // Early release during the second grant cycle
      do_reset();
      step(4'b0011, 1'b0);
      step(4'b0011, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b0010, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);

      // Sole requester past the hold limit
      for (int i = 0; i < 14; i++) step(4'b0100, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);

      // Pointer priority after requester 1 releases
      do_reset();
      step(4'b0010, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b1010, 1'b0);

      // Reset mid-grant, then full contention restarts at index 0
      for (int i = 0; i < 2; i++) step(4'b0100, 1'b0);
      bus.req = 4'b1111;
      do_reset();
      for (int i = 0; i < 6; i++) step(4'b1111, 1'b0);

      // Randomised requests with sticky patterns and random data
      r = 4'b0000;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom);
         if (i == 200) do_reset();
         step(r, 1'b1);
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
